// File: rtl/vga_bounce_renderer.sv
// vga_bounce_renderer: pixel stage behind the VGA timing generator.
// Draws a square box that bounces off the visible-area edges. The position
// steps once per frame on frame_tick, which lands in vertical blanking.
// rgb/hsync/vsync share a 2-cycle latency so sync-to-pixel alignment holds.
// Optional feature macro: VGA_BORDER_EN paints a 1-pixel white frame around
// the visible area, with priority over the box and the background.
module vga_bounce_renderer #(
  parameter int          H_RES     = 1920,
  parameter int          V_RES     = 1080,
  parameter int          BOX_SIZE  = 64,
  parameter int          STEP      = 2,
  parameter logic [11:0] BG_COLOR  = 12'h000,
  parameter logic [11:0] BOX_COLOR = 12'hF80,
  parameter int          INIT_X    = 0,
  parameter int          INIT_Y    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [11:0] h_count,
  input  logic [11:0] v_count,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] box_x,
  output logic [11:0] box_y,
  output logic        frame_tick
);

  // 13-bit constants so box+size and box+step never overflow.
  localparam logic [12:0] X_MAX   = 13'(H_RES - BOX_SIZE);
  localparam logic [12:0] Y_MAX   = 13'(V_RES - BOX_SIZE);
  localparam logic [12:0] STEP13  = 13'(STEP);
  localparam logic [12:0] SIZE13  = 13'(BOX_SIZE);
  localparam logic [12:0] VRES13  = 13'(V_RES);
  localparam logic [11:0] INIT_X12 = 12'(INIT_X);
  localparam logic [11:0] INIT_Y12 = 12'(INIT_Y);
`ifdef VGA_BORDER_EN
  localparam logic [11:0] H_LAST  = 12'(H_RES - 1);
  localparam logic [11:0] V_LAST  = 12'(V_RES - 1);
`endif

  // One axis of the bounce: returns {new_dir, new_pos}; dir 0 = +, 1 = -.
  // Moving past an edge clamps to that edge and reverses direction.
  function automatic logic [12:0] axis_next(input logic [11:0] pos,
                                             input logic dir,
                                             input logic [12:0] pmax);
    logic [12:0] p13;
    p13 = {1'b0, pos};
    if (!dir) begin
      if (p13 + STEP13 > pmax) axis_next = {1'b1, pmax[11:0]};
      else                     axis_next = {1'b0, 12'(p13 + STEP13)};
    end else begin
      if (p13 < STEP13)        axis_next = {1'b0, 12'd0};
      else                     axis_next = {1'b1, 12'(p13 - STEP13)};
    end
  endfunction

  logic        frame_tick_q, frame_tick_d;
  logic [11:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic        inside_q, inside_d;
  logic        von_q, hs1_q, vs1_q;
  logic [11:0] rgb_q, rgb_d;
  logic        hs2_q, vs2_q;
`ifdef VGA_BORDER_EN
  logic        border_q, border_d;
`endif

  // Frame tick on the first pixel of line V_RES (start of vertical blanking).
  always_comb begin
    frame_tick_d = (h_count == 12'd0) && ({1'b0, v_count} == VRES13);
  end

  // Box motion: steps only on an enabled frame tick, otherwise holds.
  always_comb begin
    logic [12:0] nx, ny;
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    nx = axis_next(box_x_q, dir_x_q, X_MAX);
    ny = axis_next(box_y_q, dir_y_q, Y_MAX);
    if (frame_tick_q && en) begin
      {dir_x_d, box_x_d} = nx;
      {dir_y_d, box_y_d} = ny;
    end
  end

  // Stage 1 decode: box hit test (and border flag when enabled).
  always_comb begin
    logic [12:0] h13, v13, bx13, by13;
    h13  = {1'b0, h_count};
    v13  = {1'b0, v_count};
    bx13 = {1'b0, box_x_q};
    by13 = {1'b0, box_y_q};
    inside_d = (h13 >= bx13) && (h13 < bx13 + SIZE13) &&
               (v13 >= by13) && (v13 < by13 + SIZE13);
`ifdef VGA_BORDER_EN
    border_d = (h_count == 12'd0) || (h_count == H_LAST) ||
               (v_count == 12'd0) || (v_count == V_LAST);
`endif
  end

  // Stage 2 colour select; blanking forces black regardless of decode.
  always_comb begin
    rgb_d = BG_COLOR;
    if (!von_q)        rgb_d = 12'h000;
`ifdef VGA_BORDER_EN
    else if (border_q) rgb_d = 12'hFFF;
`endif
    else if (inside_q) rgb_d = BOX_COLOR;
  end

  // All state: position/direction, frame tick, and both pipeline stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_tick_q <= 1'b0;
      box_x_q      <= INIT_X12;
      box_y_q      <= INIT_Y12;
      dir_x_q      <= 1'b0;
      dir_y_q      <= 1'b0;
      inside_q     <= 1'b0;
      von_q        <= 1'b0;
      hs1_q        <= 1'b0;
      vs1_q        <= 1'b0;
      rgb_q        <= 12'h000;
      hs2_q        <= 1'b0;
      vs2_q        <= 1'b0;
`ifdef VGA_BORDER_EN
      border_q     <= 1'b0;
`endif
    end else begin
      frame_tick_q <= frame_tick_d;
      box_x_q      <= box_x_d;
      box_y_q      <= box_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      inside_q     <= inside_d;
      von_q        <= video_on;
      hs1_q        <= hsync_in;
      vs1_q        <= vsync_in;
      rgb_q        <= rgb_d;
      hs2_q        <= hs1_q;
      vs2_q        <= vs1_q;
`ifdef VGA_BORDER_EN
      border_q     <= border_d;
`endif
    end
  end

  assign rgb        = rgb_q;
  assign hsync      = hs2_q;
  assign vsync      = vs2_q;
  assign box_x      = box_x_q;
  assign box_y      = box_y_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_bounce_renderer.sv
// Bench for vga_bounce_renderer: drives the counters directly with a small
// 16x12 screen, 4-pixel box, step 3. Expected values come from a plain
// integer bounce model and a pixel-colour function.
module tb_vga_bounce_renderer;

  localparam int          H   = 16;
  localparam int          V   = 12;
  localparam int          BS  = 4;
  localparam int          ST  = 3;
  localparam logic [11:0] BG  = 12'h035;
  localparam logic [11:0] BOX = 12'hF80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, video_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [11:0] h_count = '0, v_count = '0;
  logic [11:0] rgb, box_x, box_y;
  logic        hsync, vsync, frame_tick;

  int checks = 0;
  int errors = 0;

  // reference model state: box position and direction as signed ints
  int mx, my, mdx, mdy;

  vga_bounce_renderer #(
    .H_RES(H), .V_RES(V), .BOX_SIZE(BS), .STEP(ST),
    .BG_COLOR(BG), .BOX_COLOR(BOX), .INIT_X(0), .INIT_Y(0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .h_count(h_count), .v_count(v_count),
    .rgb(rgb), .hsync(hsync), .vsync(vsync),
    .box_x(box_x), .box_y(box_y), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] exp_rgb(int h, int v, bit von, int bx, int by);
    if (!von) return 12'h000;
`ifdef VGA_BORDER_EN
    if (h == 0 || h == H-1 || v == 0 || v == V-1) return 12'hFFF;
`endif
    if (h >= bx && h < bx + BS && v >= by && v < by + BS) return BOX;
    return BG;
  endfunction

  // Bounce rule: move by STEP; overshooting an edge lands on it and reverses.
  task automatic model_tick();
    int tx, ty;
    tx = mx + mdx * ST;
    ty = my + mdy * ST;
    if (tx > H - BS) begin mx = H - BS; mdx = -1; end
    else if (tx < 0) begin mx = 0;      mdx = 1;  end
    else mx = tx;
    if (ty > V - BS) begin my = V - BS; mdy = -1; end
    else if (ty < 0) begin my = 0;      mdy = 1;  end
    else my = ty;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int h, int v, bit von, bit hs, bit vs);
    h_count  = 12'(h);
    v_count  = 12'(v);
    video_on = von;
    hsync_in = hs;
    vsync_in = vs;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    cyc();
    rst = 1'b0;
    cyc();
    mx = 0; my = 0; mdx = 1; mdy = 1;
  endtask

  // Presents line V_RES pixel 0 for one cycle; reports frame_tick on the
  // following two sample points. Box update is visible after return.
  task automatic pulse_frame(output logic ft_hi, output logic ft_after);
    drive(0, V, 0, 0, 1);
    cyc();
    ft_hi = frame_tick;
    drive(1, V, 0, 0, 1);
    cyc();
    ft_after = frame_tick;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1, 1, 1, 1);
    cyc(); cyc();
    checks++;
    if (rgb !== 12'h000 || hsync !== 1'b0 || vsync !== 1'b0 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs rgb=%h hs=%b vs=%b ft=%b want 000/0/0/0", rgb, hsync, vsync, frame_tick);
    end
    checks++;
    if (box_x !== 12'd0 || box_y !== 12'd0) begin
      errors++;
      $display("FAIL reset_box got %0d,%0d want 0,0", box_x, box_y);
    end
    reset_dut();
  endtask

  task automatic test_directed();
    reset_dut();
    en = 1'b0;
    drive(1, 1, 1, 0, 0); cyc(); cyc();
    checks++;
    if (rgb !== BOX) begin errors++; $display("FAIL box_pixel got %h want %h", rgb, BOX); end
    drive(5, 1, 1, 0, 0); cyc(); cyc();
    checks++;
    if (rgb !== BG) begin errors++; $display("FAIL bg_pixel got %h want %h", rgb, BG); end
    drive(1, 1, 0, 0, 0); cyc(); cyc();
    checks++;
    if (rgb !== 12'h000) begin errors++; $display("FAIL blank_pixel got %h want 000", rgb); end
    // hsync 1,0,1 must reappear two cycles later
    drive(5, 1, 1, 1, 0); cyc();
    checks++;
    if (hsync !== 1'b0) begin errors++; $display("FAIL hsync_lat1 got %b want 0", hsync); end
    drive(5, 1, 1, 0, 0); cyc();
    checks++;
    if (hsync !== 1'b1) begin errors++; $display("FAIL hsync_p0 got %b want 1", hsync); end
    drive(5, 1, 1, 1, 0); cyc();
    checks++;
    if (hsync !== 1'b0) begin errors++; $display("FAIL hsync_p1 got %b want 0", hsync); end
    cyc();
    checks++;
    if (hsync !== 1'b1 || rgb !== BG) begin
      errors++; $display("FAIL hsync_p2 got hs=%b rgb=%h want 1/%h", hsync, rgb, BG);
    end
    drive(0, 5, 1, 0, 0); cyc(); cyc();
    checks++;
`ifdef VGA_BORDER_EN
    if (rgb !== 12'hFFF) begin errors++; $display("FAIL border_pixel got %h want FFF", rgb); end
`else
    if (rgb !== BG) begin errors++; $display("FAIL edge_pixel got %h want %h", rgb, BG); end
`endif
  endtask

  // Random pixel stream, compared 2 cycles later against the colour model.
  task automatic test_random_pixels(int n);
    logic [11:0] q_rgb[$];
    logic        q_hs[$], q_vs[$];
    logic [11:0] e_rgb;
    logic        e_hs, e_vs;
    en = 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        int h, v;
        bit von, hs, vs;
        h   = $urandom_range(0, H + 3);
        v   = $urandom_range(0, V + 1);
        von = ($urandom_range(0, 3) != 0) && h < H && v < V;
        hs  = 1'($urandom_range(0, 1));
        vs  = 1'($urandom_range(0, 1));
        drive(h, v, von, hs, vs);
        q_rgb.push_back(exp_rgb(h, v, von, mx, my));
        q_hs.push_back(hs);
        q_vs.push_back(vs);
      end
      cyc();
      if (i >= 1) begin
        e_rgb = q_rgb.pop_front();
        e_hs  = q_hs.pop_front();
        e_vs  = q_vs.pop_front();
        checks++;
        if (rgb !== e_rgb || hsync !== e_hs || vsync !== e_vs) begin
          errors++;
          $display("FAIL rand_pixel[%0d] got rgb=%h hs=%b vs=%b want %h/%b/%b", i, rgb, hsync, vsync, e_rgb, e_hs, e_vs);
        end
      end
    end
  endtask

  task automatic test_motion();
    int xs[7] = '{3, 6, 9, 12, 12, 9, 6};
    int ys[7] = '{3, 6, 8, 5, 2, 0, 3};
    logic ft1, ft2;
    reset_dut();
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pulse_frame(ft1, ft2);
      model_tick();
      checks++;
      if (box_x !== 12'(xs[i]) || box_y !== 12'(ys[i]) || ft1 !== 1'b1 || ft2 !== 1'b0) begin
        errors++;
        $display("FAIL motion_seq[%0d] got %0d,%0d ft=%b%b want %0d,%0d ft=10", i, box_x, box_y, ft1, ft2, xs[i], ys[i]);
      end
    end
    for (int i = 0; i < 24; i++) begin
      en = 1'($urandom_range(0, 3) != 0);
      pulse_frame(ft1, ft2);
      if (en) model_tick();
      checks++;
      if (box_x !== 12'(mx) || box_y !== 12'(my)) begin
        errors++;
        $display("FAIL motion_rand[%0d] got %0d,%0d want %0d,%0d", i, box_x, box_y, mx, my);
      end
    end
  endtask

  task automatic test_en_off();
    logic ft1, ft2;
    int pulses;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse_frame(ft1, ft2);
      pulses = 0;
      // rest of the blanking line and next frame's lines: no further pulse
      for (int j = 2; j < 8; j++) begin
        drive(j, (j < 5) ? V : 2, 0, 0, 0);
        cyc();
        if (frame_tick === 1'b1) pulses++;
      end
      checks++;
      if (box_x !== 12'(mx) || box_y !== 12'(my) || ft1 !== 1'b1 || ft2 !== 1'b0 || pulses != 0) begin
        errors++;
        $display("FAIL en_off[%0d] got %0d,%0d ft=%b%b extra=%0d want %0d,%0d ft=10 extra=0", i, box_x, box_y, ft1, ft2, pulses, mx, my);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic ft1, ft2;
    reset_dut();
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin pulse_frame(ft1, ft2); model_tick(); end
    checks++;
    if (box_x !== 12'd9 || box_y !== 12'd8) begin
      errors++; $display("FAIL pre_reset_pos got %0d,%0d want 9,8", box_x, box_y);
    end
    drive(10, 9, 1, 1, 1); cyc(); cyc();
    checks++;
    if (rgb !== BOX || hsync !== 1'b1 || vsync !== 1'b1) begin
      errors++; $display("FAIL pre_reset_pix got %h/%b/%b want %h/1/1", rgb, hsync, vsync, BOX);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rgb !== 12'h000 || hsync !== 1'b0 || vsync !== 1'b0 || box_x !== 12'd0 || box_y !== 12'd0) begin
      errors++;
      $display("FAIL async_reset got rgb=%h hs=%b vs=%b box=%0d,%0d want 000/0/0 0,0", rgb, hsync, vsync, box_x, box_y);
    end
    #2 rst = 1'b0;
    mx = 0; my = 0; mdx = 1; mdy = 1;
    drive(1, 1, 1, 0, 0); cyc(); cyc();
    checks++;
    if (rgb !== BOX || frame_tick !== 1'b0) begin
      errors++; $display("FAIL refill got rgb=%h ft=%b want %h/0", rgb, frame_tick, BOX);
    end
    pulse_frame(ft1, ft2);
    model_tick();
    checks++;
    if (ft1 !== 1'b1 || ft2 !== 1'b0 || box_x !== 12'd3 || box_y !== 12'd3) begin
      errors++; $display("FAIL first_tick got ft=%b%b box=%0d,%0d want 10 3,3", ft1, ft2, box_x, box_y);
    end
  endtask

  initial begin
    mx = 0; my = 0; mdx = 1; mdy = 1;
    test_reset();
    test_directed();
    test_random_pixels(60);
    test_motion();
    test_random_pixels(80);
    test_en_off();
    test_reset_mid();
    test_random_pixels(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
